// File: rtl/lvc_ahb_pkg.sv
// Shared AHB-Lite encodings, plus the SRAM slave's FSM state type and byte-lane helper.
package lvc_ahb_pkg;

   typedef enum logic [1:0] {
      OKAY  = 2'b00,
      ERROR = 2'b01,
      RETRY = 2'b10,
      SPLIT = 2'b11
   } response_type_enum;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } trans_type_enum;

   typedef enum logic [2:0] {
      BURST_SIZE_8BIT    = 3'd0,
      BURST_SIZE_16BIT   = 3'd1,
      BURST_SIZE_32BIT   = 3'd2,
      BURST_SIZE_64BIT   = 3'd3,
      BURST_SIZE_128BIT  = 3'd4,
      BURST_SIZE_256BIT  = 3'd5,
      BURST_SIZE_512BIT  = 3'd6,
      BURST_SIZE_1024BIT = 3'd7
   } burst_size_enum;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_STALL = 3'd3,
      ST_ERR1  = 3'd4,
      ST_ERR2  = 3'd5
   } sram_state_enum;

   localparam int unsigned BE_WIDTH = 4;

   // Lane enables for a 32-bit little-endian bus.
   function automatic logic [BE_WIDTH-1:0] byte_enables(input burst_size_enum size,
                                                        input logic [1:0] lane);
      case (size)
         BURST_SIZE_8BIT:  return 4'b0001 << lane;
         BURST_SIZE_16BIT: return 4'b0011 << {lane[1], 1'b0};
         default:          return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Synchronous single-port SRAM, MEM_WORDS x 32, byte-enabled writes, registered read data.
module ahb_sram_mem #(
   parameter int unsigned  MEM_WORDS = 1024,
   localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
   input  logic          clk,
   input  logic          cs,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave controller for an external single-port SRAM: zero-wait reads and writes,
// one stall cycle on a write->read port conflict, two-cycle ERROR response.
module ahb_sram_slave
   import lvc_ahb_pkg::*;
#(
   parameter int unsigned  ADDR_WIDTH = 32,
   parameter int unsigned  DATA_WIDTH = 32,
   parameter int unsigned  MEM_WORDS  = 1024,
   localparam int unsigned SRAM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic                  hsel,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic                  hready,
   output logic                  hreadyout,
   output logic [1:0]            hresp,
   output logic [DATA_WIDTH-1:0] hrdata,
   output logic                  sram_cs,
   output logic                  sram_we,
   output logic [BE_WIDTH-1:0]   sram_be,
   output logic [SRAM_AW-1:0]    sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);

   // one spare bit so the range check cannot wrap for any legal MEM_WORDS
   localparam int unsigned IDX_W = ADDR_WIDTH - 1;

   sram_state_enum       state_q, state_d;
   logic [SRAM_AW-1:0]   addr_q, addr_d;
   logic [BE_WIDTH-1:0]  be_q, be_d;
   logic [2:0]           size_q, size_d;

   trans_type_enum       trans;
   burst_size_enum       size;
   logic                 accept;
   logic                 xfer_err;
   logic [IDX_W-1:0]     word_idx;
   logic [SRAM_AW-1:0]   ap_addr;
   logic [BE_WIDTH-1:0]  ap_be;
   logic                 unused_bus;

   assign trans    = trans_type_enum'(htrans);
   assign size     = burst_size_enum'(hsize);
   assign accept   = hresetn && hsel && hready && (trans == NONSEQ || trans == SEQ);
   assign word_idx = IDX_W'(haddr[ADDR_WIDTH-1:2]);
   assign xfer_err = (hsize > 3'(BURST_SIZE_32BIT))
                  || (size == BURST_SIZE_16BIT && haddr[0])
                  || (size == BURST_SIZE_32BIT && haddr[1:0] != 2'b00)
                  || (word_idx >= IDX_W'(MEM_WORDS));
   assign ap_addr  = haddr[SRAM_AW+1:2];
   assign ap_be    = byte_enables(size, haddr[1:0]);
   assign unused_bus = ^{hburst, hprot, size_q};

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         be_q    <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         size_q  <= size_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      be_d       = be_q;
      size_d     = size_q;
      hreadyout  = 1'b1;
      hresp      = OKAY;
      hrdata     = '0;
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_be    = '0;
      sram_addr  = '0;
      sram_wdata = '0;

      case (state_q)
         ST_WRITE: begin
            sram_cs    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = addr_q;
            sram_be    = be_q;
            sram_wdata = hwdata;
         end
         ST_READ: hrdata = sram_rdata;
         ST_STALL: begin
            // port was busy with the write last cycle; replay the held read now
            hreadyout = 1'b0;
            sram_cs   = 1'b1;
            sram_addr = addr_q;
            sram_be   = be_q;
            state_d   = ST_READ;
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = ERROR;
            state_d   = ST_ERR2;
         end
         ST_ERR2: hresp = ERROR;
         default: ;
      endcase

      // data phase completes this cycle: take the next address phase
      if (state_q != ST_STALL && state_q != ST_ERR1) begin
         state_d = ST_IDLE;
         if (accept) begin
            addr_d = ap_addr;
            be_d   = ap_be;
            size_d = hsize;
            if (xfer_err) begin
               state_d = ST_ERR1;
            end else if (hwrite) begin
               state_d = ST_WRITE;
            end else if (state_q == ST_WRITE) begin
               state_d = ST_STALL;
            end else begin
               state_d   = ST_READ;
               sram_cs   = 1'b1;
               sram_addr = ap_addr;
               sram_be   = ap_be;
            end
         end
      end

      if (!hresetn) begin
         sram_cs = 1'b0;
         sram_we = 1'b0;
         sram_be = '0;
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave driving a pipelined AHB master against ahb_sram_mem.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
   import lvc_ahb_pkg::*;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned MEM_WORDS  = 1024;
   localparam int unsigned SRAM_AW    = 10;

   logic                  hclk = 1'b0;
   logic                  hresetn, hsel, hwrite, hready, hreadyout;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans, hresp;
   logic [2:0]            hsize, hburst;
   logic [3:0]            hprot;
   logic [DATA_WIDTH-1:0] hwdata, hrdata;
   logic                  sram_cs, sram_we;
   logic [3:0]            sram_be;
   logic [SRAM_AW-1:0]    sram_addr;
   logic [31:0]           sram_wdata, sram_rdata;

   always #5 hclk = ~hclk;
   assign hready = hreadyout;

   ahb_sram_slave #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_WORDS(MEM_WORDS)) dut (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
      .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
      .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

   ahb_sram_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
      .clk(hclk), .cs(sram_cs), .we(sram_we), .be(sram_be), .addr(sram_addr),
      .wdata(sram_wdata), .rdata(sram_rdata));

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   typedef struct {
      logic        is_read;
      logic        err;
      logic [31:0] rdata;
      int          waits;
      logic [31:0] addr;
   } exp_t;

   xfer_t       stim_q[$];
   exp_t        sb_q[$];
   logic [31:0] ref_mem [int];
   int          n_vec = 0;
   int          n_err = 0;

   function automatic bit is_live(input xfer_t x);
      return x.sel && x.trans[1];
   endfunction

   function automatic bit is_bad(input xfer_t x);
      if (x.size > 3'd2) return 1'b1;
      if (x.size == 3'd1 && x.addr[0]) return 1'b1;
      if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b1;
      return (x.addr >> 2) >= MEM_WORDS;
   endfunction

   function automatic void add(input bit sel, input logic [1:0] trans, input bit write,
                               input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] value);
      xfer_t x;
      x.sel = sel; x.trans = trans; x.write = write; x.size = size; x.addr = addr;
      x.data = value << (8 * addr[1:0]);
      stim_q.push_back(x);
   endfunction

   function automatic void wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] v);
      add(1'b1, 2'b10, 1'b1, size, addr, v);
   endfunction

   function automatic void rd(input logic [31:0] addr, input logic [2:0] size);
      add(1'b1, 2'b10, 1'b0, size, addr, 32'h0);
   endfunction

   function automatic void idle();
      add(1'b0, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
   endfunction

   function automatic void model_write(input xfer_t x);
      int          idx, lo, n;
      logic [31:0] w;
      idx = int'(x.addr >> 2);
      lo  = int'(x.addr[1:0]);
      n   = 1 << x.size;
      w   = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
      for (int b = lo; b < lo + n; b++) w[8*b +: 8] = x.data[8*b +: 8];
      ref_mem[idx] = w;
   endfunction

   task automatic drive(input xfer_t x);
      hsel = x.sel; htrans = x.trans; hwrite = x.write; hsize = x.size; haddr = x.addr;
   endtask

   task automatic drive_idle();
      hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; haddr = '0;
   endtask

   // Pipelined master: address phase of one item overlaps the data phase of the previous.
   task automatic run_seq(input string tag);
      xfer_t ap, dp;
      exp_t  e, cur;
      bit    ap_v, dp_v, prev_wr;
      int    waits, guard, idx;
      ap_v = 1'b0; dp_v = 1'b0; waits = 0; guard = 0;
      if (stim_q.size() == 0) return;
      @(posedge hclk); #1;
      ap = stim_q.pop_front(); ap_v = 1'b1; drive(ap);
      forever begin
         @(negedge hclk);
         guard++;
         if (!((ap_v && is_live(ap) && !is_bad(ap)) || (dp_v && is_live(dp) && !is_bad(dp)))) begin
            n_vec++;
            if (sram_cs !== 1'b0) begin
               n_err++; $display("FAIL %s sram_quiet: sram_cs=%b required 0", tag, sram_cs);
            end
         end
         if (dp_v && !hreadyout) begin
            waits++;
            if (sb_q.size() > 0 && sb_q[0].err) begin
               n_vec++;
               if (hresp !== 2'b01) begin
                  n_err++; $display("FAIL %s err1_resp @%h: hresp=%b required 01", tag, sb_q[0].addr, hresp);
               end
            end
         end
         if (hreadyout) begin
            if (dp_v) begin
               cur = sb_q.pop_front();
               n_vec++;
               if (hresp !== (cur.err ? 2'b01 : 2'b00)) begin
                  n_err++; $display("FAIL %s resp @%h: hresp=%b required %b", tag, cur.addr, hresp, cur.err ? 2'b01 : 2'b00);
               end
               n_vec++;
               if (waits !== cur.waits) begin
                  n_err++; $display("FAIL %s waits @%h: got %0d required %0d", tag, cur.addr, waits, cur.waits);
               end
               n_vec++;
               if (hrdata !== ((cur.is_read && !cur.err) ? cur.rdata : 32'h0)) begin
                  n_err++; $display("FAIL %s rdata @%h: hrdata=%h required %h", tag, cur.addr, hrdata,
                                    (cur.is_read && !cur.err) ? cur.rdata : 32'h0);
               end
            end
            prev_wr = dp_v && is_live(dp) && !is_bad(dp) && dp.write;
            dp_v = ap_v; dp = ap; ap_v = 1'b0; waits = 0;
            if (dp_v) begin
               e.is_read = is_live(dp) && !dp.write;
               e.err     = is_live(dp) && is_bad(dp);
               e.addr    = dp.addr;
               e.waits   = (e.err || (e.is_read && prev_wr)) ? 1 : 0;
               e.rdata   = 32'h0;
               idx       = int'(dp.addr >> 2);
               if (e.is_read && !e.err && ref_mem.exists(idx)) e.rdata = ref_mem[idx];
               if (is_live(dp) && dp.write && !e.err) model_write(dp);
               sb_q.push_back(e);
            end
            if (stim_q.size() > 0) begin
               ap = stim_q.pop_front(); ap_v = 1'b1;
            end
         end
         if (!dp_v && !ap_v) break;
         if (guard > 500) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout: %0d cycles without completion, required <= 500", tag, guard);
            sb_q.delete(); stim_q.delete();
            break;
         end
         @(posedge hclk); #1;
         if (ap_v) drive(ap); else drive_idle();
         hwdata = (dp_v && dp.write) ? dp.data : 32'h0;
      end
      @(posedge hclk); #1;
      drive_idle();
      hwdata = 32'h0;
   endtask

   task automatic test_reset();
      hresetn = 1'b0; drive_idle(); hwdata = '0; hburst = 3'b000; hprot = 4'b0011;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      n_vec++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL reset hreadyout: %b required 1", hreadyout); end
      n_vec++; if (hresp !== 2'b00)    begin n_err++; $display("FAIL reset hresp: %b required 00", hresp); end
      n_vec++; if (hrdata !== 32'h0)   begin n_err++; $display("FAIL reset hrdata: %h required 0", hrdata); end
      n_vec++; if (sram_cs !== 1'b0)   begin n_err++; $display("FAIL reset sram_cs: %b required 0", sram_cs); end
      n_vec++; if (sram_we !== 1'b0)   begin n_err++; $display("FAIL reset sram_we: %b required 0", sram_we); end
      n_vec++; if (sram_be !== 4'h0)   begin n_err++; $display("FAIL reset sram_be: %h required 0", sram_be); end
      @(posedge hclk); #1;
      hresetn = 1'b1;
   endtask

   task automatic test_word_rw();
      wr(32'h0, 3'd2, 32'h5A5A_0F0F);
      wr(32'h10, 3'd2, 32'hDEAD_BEEF);
      idle();
      rd(32'h10, 3'd2);
      rd(32'h0, 3'd2);
      run_seq("word_rw");
   endtask

   task automatic test_byte_lanes();
      wr(32'h20, 3'd0, 32'h11);
      wr(32'h21, 3'd0, 32'h22);
      wr(32'h22, 3'd0, 32'h33);
      wr(32'h23, 3'd0, 32'h44);
      idle();
      rd(32'h20, 3'd2);
      wr(32'h24, 3'd2, 32'h0);
      wr(32'h26, 3'd1, 32'hBEEF);
      wr(32'h24, 3'd1, 32'hCAFE);
      idle();
      rd(32'h24, 3'd2);
      rd(32'h23, 3'd0);
      run_seq("byte_lanes");
   endtask

   task automatic test_write_then_read();
      wr(32'h30, 3'd2, 32'h1234_5678);
      rd(32'h30, 3'd2);
      rd(32'h10, 3'd2);
      run_seq("wr_then_rd");
   endtask

   task automatic test_errors();
      rd(32'h2, 3'd2);
      idle();
      wr(4 * MEM_WORDS, 3'd2, 32'hFFFF_FFFF);
      idle();
      rd(32'h8, 3'd3);
      idle();
      wr(32'h11, 3'd1, 32'hFFFF);
      idle();
      rd(32'h2, 3'd2);
      rd(32'h10, 3'd2);
      idle();
      rd(32'h0, 3'd2);
      run_seq("errors");
   endtask

   task automatic test_burst();
      hburst = 3'b011;
      add(1'b1, 2'b10, 1'b1, 3'd2, 32'h40, 32'hA0A0_0000);
      add(1'b1, 2'b11, 1'b1, 3'd2, 32'h44, 32'hA1A1_1111);
      add(1'b1, 2'b01, 1'b1, 3'd2, 32'h48, 32'h0);
      add(1'b1, 2'b11, 1'b1, 3'd2, 32'h48, 32'hA2A2_2222);
      add(1'b1, 2'b11, 1'b1, 3'd2, 32'h4C, 32'hA3A3_3333);
      add(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
      add(1'b1, 2'b11, 1'b0, 3'd2, 32'h44, 32'h0);
      add(1'b1, 2'b01, 1'b0, 3'd2, 32'h48, 32'h0);
      add(1'b1, 2'b11, 1'b0, 3'd2, 32'h48, 32'h0);
      add(1'b1, 2'b11, 1'b0, 3'd2, 32'h4C, 32'h0);
      run_seq("burst");
      hburst = 3'b000;
   endtask

   task automatic test_deselect();
      add(1'b0, 2'b10, 1'b1, 3'd2, 32'h10, 32'hFFFF_FFFF);
      add(1'b0, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
      idle();
      rd(32'h10, 3'd2);
      run_seq("deselect");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) wr(32'h100 + 32'(4 * i), 3'd2, $urandom);
      for (int i = 0; i < 8; i++) rd(32'h100 + 32'(4 * i), 3'd2);
      wr(32'h105, 3'd0, 32'h77);
      rd(32'h104, 3'd2);
      run_seq("back_to_back");
   endtask

   task automatic test_reset_mid_write();
      wr(32'h50, 3'd2, 32'hCAFE_F00D);
      run_seq("rst_pre");
      @(posedge hclk); #1;
      hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h50;
      @(posedge hclk); #1;
      drive_idle();
      hwdata  = 32'h0BAD_0BAD;
      hresetn = 1'b0;
      @(negedge hclk);
      n_vec++; if (sram_we !== 1'b0) begin n_err++; $display("FAIL rst_mid sram_we_in_reset: %b required 0", sram_we); end
      @(negedge hclk);
      n_vec++; if (hreadyout !== 1'b1) begin n_err++; $display("FAIL rst_mid hreadyout: %b required 1", hreadyout); end
      n_vec++; if (hresp !== 2'b00)    begin n_err++; $display("FAIL rst_mid hresp: %b required 00", hresp); end
      n_vec++; if (hrdata !== 32'h0)   begin n_err++; $display("FAIL rst_mid hrdata: %h required 0", hrdata); end
      n_vec++; if (sram_cs !== 1'b0)   begin n_err++; $display("FAIL rst_mid sram_cs: %b required 0", sram_cs); end
      n_vec++; if (sram_be !== 4'h0)   begin n_err++; $display("FAIL rst_mid sram_be: %h required 0", sram_be); end
      @(posedge hclk); #1;
      hresetn = 1'b1;
      hwdata  = 32'h0;
      rd(32'h50, 3'd2);
      run_seq("rst_post");
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_write_then_read();
      test_errors();
      test_burst();
      test_deselect();
      test_back_to_back();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
